// File: rtl/frame_err_check_p.sv
// frame_err_check_p
//   Receive-side frame checker between the byte deserialiser and the message
//   decoder. Frame: MARKER, FLAG, reserved, LEN, LEN payload bytes, CRC_BYTES
//   CRC bytes (MSB first). Reports a registered error vector with a valid
//   strobe and keeps saturating frame / error-frame statistics.
//
// Ports
//   clk            system clock
//   n_rst          asynchronous active-low reset
//   d, d_rdy       received byte and its one-cycle valid strobe
//   pb_err         parity error on the current byte (qualified by d_rdy)
//   crc            running CRC from the external calculator
//   rx_frame_end   one-cycle end-of-frame pulse from the line layer
//   crc_update_en  external CRC calculator may absorb the current byte
//   crc_rst        one-cycle clear pulse to the external CRC calculator
//   rx_flag        FLAG byte of the last frame
//   rx_len         LEN byte of the last frame
//   rx_errs        {overrun, crc, parity, len, flag, marker, ok}
//   rx_errs_vld    one-cycle strobe, rx_errs valid
//   frame_cnt      frames completed (saturating)
//   err_frame_cnt  frames reported not ok (saturating)
//
// state    | meaning
// S_HDR    | header bytes 0..3 (marker, flag, reserved, len)
// S_PAY    | payload bytes
// S_CRC    | CRC bytes shifting into rcv_crc
// S_TAIL   | frame complete, any further byte is an overrun
// S_REPORT | one cycle: register error vector, bump counters, clear frame

module frame_err_check_p #(
   parameter logic [7:0] MARKER    = 8'hA5,
   parameter logic [7:0] FLAG_MIN  = 8'h01,
   parameter logic [7:0] FLAG_MAX  = 8'h07,
   parameter int         MAX_LEN   = 64,
   parameter int         CRC_BYTES = 2,
   parameter int         STAT_W    = 16
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [7:0]             d,
   input  logic                   d_rdy,
   input  logic                   pb_err,
   input  logic [8*CRC_BYTES-1:0] crc,
   input  logic                   rx_frame_end,
   output logic                   crc_update_en,
   output logic                   crc_rst,
   output logic [7:0]             rx_flag,
   output logic [7:0]             rx_len,
   output logic [6:0]             rx_errs,
   output logic                   rx_errs_vld,
   output logic [STAT_W-1:0]      frame_cnt,
   output logic [STAT_W-1:0]      err_frame_cnt
);

   localparam int         CRC_W     = 8 * CRC_BYTES;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [8:0] CRC_B9    = 9'(CRC_BYTES);

   typedef enum logic [2:0] {
      S_HDR    = 3'd0,
      S_PAY    = 3'd1,
      S_CRC    = 3'd2,
      S_TAIL   = 3'd3,
      S_REPORT = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [8:0]         bcnt_q, bcnt_d;
   logic [7:0]         exp_len_q, exp_len_d;
   logic [7:0]         rx_flag_q, rx_flag_d;
   logic [7:0]         rx_len_q, rx_len_d;
   logic [CRC_W-1:0]   rcv_crc_q, rcv_crc_d;
   logic [CRC_W-1:0]   crc_snap_q, crc_snap_d;
   logic               snap_pend_q, snap_pend_d;
   logic               mrk_bad_q, mrk_bad_d;
   logic               flg_bad_q, flg_bad_d;
   logic               len_bad_q, len_bad_d;
   logic               par_bad_q, par_bad_d;
   logic               ovr_q, ovr_d;
   logic               tail_q, tail_d;
   logic [6:0]         rx_errs_q, rx_errs_d;
   logic               rx_errs_vld_q, rx_errs_vld_d;
   logic [STAT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [STAT_W-1:0]  err_frame_cnt_q, err_frame_cnt_d;

   logic [7:0]         len_clamp;
   logic [6:0]         errs;
   logic               short_frm;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q         <= S_HDR;
         bcnt_q          <= '0;
         exp_len_q       <= '0;
         rx_flag_q       <= '0;
         rx_len_q        <= '0;
         rcv_crc_q       <= '0;
         crc_snap_q      <= '0;
         snap_pend_q     <= 1'b0;
         mrk_bad_q       <= 1'b0;
         flg_bad_q       <= 1'b0;
         len_bad_q       <= 1'b0;
         par_bad_q       <= 1'b0;
         ovr_q           <= 1'b0;
         tail_q          <= 1'b0;
         rx_errs_q       <= '0;
         rx_errs_vld_q   <= 1'b0;
         frame_cnt_q     <= '0;
         err_frame_cnt_q <= '0;
      end else begin
         state_q         <= state_d;
         bcnt_q          <= bcnt_d;
         exp_len_q       <= exp_len_d;
         rx_flag_q       <= rx_flag_d;
         rx_len_q        <= rx_len_d;
         rcv_crc_q       <= rcv_crc_d;
         crc_snap_q      <= crc_snap_d;
         snap_pend_q     <= snap_pend_d;
         mrk_bad_q       <= mrk_bad_d;
         flg_bad_q       <= flg_bad_d;
         len_bad_q       <= len_bad_d;
         par_bad_q       <= par_bad_d;
         ovr_q           <= ovr_d;
         tail_q          <= tail_d;
         rx_errs_q       <= rx_errs_d;
         rx_errs_vld_q   <= rx_errs_vld_d;
         frame_cnt_q     <= frame_cnt_d;
         err_frame_cnt_q <= err_frame_cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      bcnt_d          = bcnt_q;
      exp_len_d       = exp_len_q;
      rx_flag_d       = rx_flag_q;
      rx_len_d        = rx_len_q;
      rcv_crc_d       = rcv_crc_q;
      crc_snap_d      = crc_snap_q;
      snap_pend_d     = snap_pend_q;
      mrk_bad_d       = mrk_bad_q;
      flg_bad_d       = flg_bad_q;
      len_bad_d       = len_bad_q;
      par_bad_d       = par_bad_q;
      ovr_d           = ovr_q;
      tail_d          = tail_q;
      rx_errs_d       = rx_errs_q;
      rx_errs_vld_d   = 1'b0;
      frame_cnt_d     = frame_cnt_q;
      err_frame_cnt_d = err_frame_cnt_q;

      len_clamp = (d > MAX_LEN_B) ? MAX_LEN_B : d;

      // A frame that never reached S_TAIL is short: both len and crc fail.
      short_frm = ~tail_q;
      errs[1]   = mrk_bad_q;
      errs[2]   = flg_bad_q;
      errs[3]   = len_bad_q | short_frm;
      errs[4]   = par_bad_q;
      errs[5]   = short_frm | (rcv_crc_q != crc_snap_q);
      errs[6]   = ovr_q;
      errs[0]   = ~|errs[6:1];

      if (state_q == S_REPORT) begin
         rx_errs_d     = errs;
         rx_errs_vld_d = 1'b1;
         if (frame_cnt_q != '1) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
         if (!errs[0] && (err_frame_cnt_q != '1)) begin
            err_frame_cnt_d = err_frame_cnt_q + 1'b1;
         end
         bcnt_d      = '0;
         rcv_crc_d   = '0;
         snap_pend_d = 1'b0;
         mrk_bad_d   = 1'b0;
         flg_bad_d   = 1'b0;
         len_bad_d   = 1'b0;
         par_bad_d   = 1'b0;
         ovr_d       = 1'b0;
         tail_d      = 1'b0;
         state_d     = S_HDR;
      end else begin
         // The external CRC absorbs the last covered byte on the edge it is
         // presented, so its final value is visible one cycle later.
         if (snap_pend_q) begin
            crc_snap_d  = crc;
            snap_pend_d = 1'b0;
         end

         if (d_rdy) begin
            if (bcnt_q != 9'h1FF) begin
               bcnt_d = bcnt_q + 9'd1;
            end
            if (pb_err) begin
               par_bad_d = 1'b1;
            end
            unique case (state_q)
               S_HDR: begin
                  unique case (bcnt_q[1:0])
                     2'd0: if (d != MARKER) mrk_bad_d = 1'b1;
                     2'd1: begin
                        rx_flag_d = d;
                        if ((d < FLAG_MIN) || (d > FLAG_MAX)) flg_bad_d = 1'b1;
                     end
                     2'd2: ;
                     2'd3: begin
                        rx_len_d  = d;
                        exp_len_d = len_clamp;
                        if (d > MAX_LEN_B) len_bad_d = 1'b1;
                        if (len_clamp == 8'd0) begin
                           state_d     = S_CRC;
                           snap_pend_d = 1'b1;
                        end else begin
                           state_d = S_PAY;
                        end
                     end
                     default: ;
                  endcase
               end
               S_PAY: begin
                  if (bcnt_q == (9'd3 + {1'b0, exp_len_q})) begin
                     state_d     = S_CRC;
                     snap_pend_d = 1'b1;
                  end
               end
               S_CRC: begin
                  rcv_crc_d = (rcv_crc_q << 8) | CRC_W'(d);
                  if (bcnt_q == (9'd3 + {1'b0, exp_len_q} + CRC_B9)) begin
                     state_d = S_TAIL;
                     tail_d  = 1'b1;
                  end
               end
               S_TAIL: ovr_d = 1'b1;
               default: ;
            endcase
         end

         // Byte in the same cycle is already folded in above.
         if (rx_frame_end) begin
            state_d = S_REPORT;
         end
      end
   end

   assign crc_update_en = (state_q == S_HDR) || (state_q == S_PAY);
   assign crc_rst       = (state_q == S_REPORT);
   assign rx_flag       = rx_flag_q;
   assign rx_len        = rx_len_q;
   assign rx_errs       = rx_errs_q;
   assign rx_errs_vld   = rx_errs_vld_q;
   assign frame_cnt     = frame_cnt_q;
   assign err_frame_cnt = err_frame_cnt_q;

endmodule

// File: tb/tb_frame_err_check_p.sv
// Directed bench for frame_err_check_p. Statistics counters are built 2 bits
// wide so that saturation is reached within a handful of frames.

module tb_frame_err_check_p;

   logic        clk;
   logic        n_rst;
   logic [7:0]  d;
   logic        d_rdy;
   logic        pb_err;
   logic [15:0] crc;
   logic        rx_frame_end;
   logic        crc_update_en;
   logic        crc_rst;
   logic [7:0]  rx_flag;
   logic [7:0]  rx_len;
   logic [6:0]  rx_errs;
   logic        rx_errs_vld;
   logic [1:0]  frame_cnt;
   logic [1:0]  err_frame_cnt;

   int n_chk;
   int n_pass;

   frame_err_check_p #(
      .STAT_W (2)
   ) u_dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .d             (d),
      .d_rdy         (d_rdy),
      .pb_err        (pb_err),
      .crc           (crc),
      .rx_frame_end  (rx_frame_end),
      .crc_update_en (crc_update_en),
      .crc_rst       (crc_rst),
      .rx_flag       (rx_flag),
      .rx_len        (rx_len),
      .rx_errs       (rx_errs),
      .rx_errs_vld   (rx_errs_vld),
      .frame_cnt     (frame_cnt),
      .err_frame_cnt (err_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic send(input logic [7:0] b, input logic pe);
      @(negedge clk);
      d      = b;
      d_rdy  = 1'b1;
      pb_err = pe;
      @(negedge clk);
      d_rdy  = 1'b0;
      pb_err = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] mk, input logic [7:0] fl, input logic [7:0] ln);
      send(mk, 1'b0);
      send(fl, 1'b0);
      send(8'h00, 1'b0);
      send(ln, 1'b0);
   endtask

   task automatic report(input string tag, input logic [6:0] e_errs, input logic [7:0] e_flag,
                         input logic [7:0] e_len, input logic [1:0] e_fc, input logic [1:0] e_efc);
      logic found;
      @(negedge clk);
      rx_frame_end = 1'b1;
      @(negedge clk);
      rx_frame_end = 1'b0;
      chk({tag, ".crc_rst"}, crc_rst, 1);
      chk({tag, ".vld_early"}, rx_errs_vld, 0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (rx_errs_vld) found = 1'b1;
      end
      chk({tag, ".vld_seen"}, found, 1);
      chk({tag, ".crc_rst_1cyc"}, crc_rst, 0);
      chk({tag, ".errs"}, rx_errs, e_errs);
      chk({tag, ".flag"}, rx_flag, e_flag);
      chk({tag, ".len"}, rx_len, e_len);
      chk({tag, ".frame_cnt"}, frame_cnt, e_fc);
      chk({tag, ".err_cnt"}, err_frame_cnt, e_efc);
      @(negedge clk);
      chk({tag, ".vld_1cyc"}, rx_errs_vld, 0);
   endtask

   initial begin
      logic seen;
      n_chk        = 0;
      n_pass       = 0;
      n_rst        = 1'b0;
      d            = 8'h00;
      d_rdy        = 1'b0;
      pb_err       = 1'b0;
      crc          = 16'h1234;
      rx_frame_end = 1'b0;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      chk("rst.errs", rx_errs, 0);
      chk("rst.vld", rx_errs_vld, 0);
      chk("rst.crc_rst", crc_rst, 0);
      chk("rst.fc", frame_cnt, 0);
      chk("rst.efc", err_frame_cnt, 0);
      chk("rst.flag", rx_flag, 0);
      chk("rst.upd_en", crc_update_en, 1);

      // good frame
      send_hdr(8'hA5, 8'h03, 8'h02);
      send(8'h11, 1'b0);
      chk("good.upd_en_pay", crc_update_en, 1);
      send(8'h22, 1'b0);
      chk("good.upd_en_crc", crc_update_en, 0);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      chk("good.upd_en_tail", crc_update_en, 0);
      report("good", 7'b0000001, 8'h03, 8'h02, 2'd1, 2'd0);

      // bad marker and flag
      send_hdr(8'h5A, 8'h09, 8'h02);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      report("mrkflg", 7'b0000110, 8'h09, 8'h02, 2'd2, 2'd1);

      // short frame: one CRC byte missing
      send_hdr(8'hA5, 8'h03, 8'h02);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h12, 1'b0);
      report("short", 7'b0101000, 8'h03, 8'h02, 2'd3, 2'd2);

      // overrun, frame counter saturated
      send_hdr(8'hA5, 8'h03, 8'h02);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      send(8'h55, 1'b0);
      report("ovr", 7'b1000000, 8'h03, 8'h02, 2'd3, 2'd3);

      // parity error on a payload byte, error counter saturated
      send_hdr(8'hA5, 8'h03, 8'h02);
      send(8'h11, 1'b1);
      send(8'h22, 1'b0);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      report("par", 7'b0010000, 8'h03, 8'h02, 2'd3, 2'd3);

      // LEN=200 clamped to 64: CRC bytes start at byte 68
      send_hdr(8'hA5, 8'h07, 8'hC8);
      for (int i = 0; i < 64; i++) begin
         if (i == 63) chk("long.upd_en_b67", crc_update_en, 1);
         send(8'(i), 1'b0);
      end
      chk("long.upd_en_b68", crc_update_en, 0);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      report("long", 7'b0001000, 8'h07, 8'hC8, 2'd3, 2'd3);

      // LEN=0 with FLAG at its minimum, wrong CRC
      send_hdr(8'hA5, 8'h01, 8'h00);
      chk("len0.upd_en", crc_update_en, 0);
      send(8'h12, 1'b0);
      send(8'h35, 1'b0);
      report("badcrc", 7'b0100000, 8'h01, 8'h00, 2'd3, 2'd3);

      // reset mid-payload, then a good frame
      send_hdr(8'hA5, 8'h03, 8'h02);
      send(8'h11, 1'b0);
      n_rst = 1'b0;
      @(negedge clk);
      chk("abort.fc", frame_cnt, 0);
      chk("abort.efc", err_frame_cnt, 0);
      chk("abort.flag", rx_flag, 0);
      n_rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rx_errs_vld || crc_rst) seen = 1'b1;
      end
      chk("abort.no_report", seen, 0);
      send_hdr(8'hA5, 8'h03, 8'h02);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      report("after", 7'b0000001, 8'h03, 8'h02, 2'd1, 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
